// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment display driver.
// - Digit code: 5 bits. Bit 4 clear -> hex nibble 0..F; bit 4 set -> blank or letter.
// - Segment patterns are {g,f,e,d,c,b,a}, active-low.
// - FSM state type for the conversion controller.
package seg7_pkg;

  localparam int unsigned DigitW = 5;
  typedef logic [DigitW-1:0] digit_t;

  localparam digit_t DIG_BLANK = 5'h10;
  localparam digit_t DIG_H     = 5'h11;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_H     = 7'h09;

  typedef enum logic [1:0] {
    StIdle,
    StConv,
    StDone
  } state_e;

  // Nibble to digit code.
  function automatic digit_t hex_digit(input logic [3:0] nib);
    return {1'b0, nib};
  endfunction

  // Digit code to active-low segment pattern; unknown codes render blank.
  function automatic logic [6:0] seg_encode(input digit_t d);
    logic [6:0] seg;
    case (d)
      5'h00:   seg = 7'h40;
      5'h01:   seg = 7'h79;
      5'h02:   seg = 7'h24;
      5'h03:   seg = 7'h30;
      5'h04:   seg = 7'h19;
      5'h05:   seg = 7'h12;
      5'h06:   seg = 7'h02;
      5'h07:   seg = 7'h78;
      5'h08:   seg = 7'h00;
      5'h09:   seg = 7'h10;
      5'h0A:   seg = 7'h08;
      5'h0B:   seg = 7'h03;
      5'h0C:   seg = 7'h46;
      5'h0D:   seg = 7'h21;
      5'h0E:   seg = 7'h06;
      5'h0F:   seg = 7'h0E;
      DIG_H:   seg = SEG_H;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter, 8-bit binary to 3-digit BCD.
// Ports:
//   Clock, Reset : system clock, synchronous active-high reset
//   start_i      : load bin_i and begin converting (ignored cycles never overlap a run)
//   bin_i[7:0]   : binary input, sampled with start_i
//   done_o       : high during the cycle whose edge performs the last (8th) iteration
//   bcd_o[11:0]  : {hundreds, tens, units}, valid from the edge after done_o
module bin2bcd_seq (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        start_i,
  input  logic [7:0]  bin_i,
  output logic        done_o,
  output logic [11:0] bcd_o
);

  // {bcd[11:0], bin[7:0]} working register
  logic [19:0] sh_q, sh_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        run_q, run_d;
  logic [19:0] adj;

  always_comb begin
    // Add-3 correction on every BCD nibble >= 5 before the shift
    adj = sh_q;
    for (int i = 0; i < 3; i++) begin
      if (sh_q[8+4*i +: 4] >= 4'd5) begin
        adj[8+4*i +: 4] = sh_q[8+4*i +: 4] + 4'd3;
      end
    end

    sh_d  = sh_q;
    cnt_d = cnt_q;
    run_d = run_q;
    if (start_i) begin
      sh_d  = {12'd0, bin_i};
      cnt_d = 3'd0;
      run_d = 1'b1;
    end else if (run_q) begin
      sh_d  = {adj[18:0], 1'b0};
      cnt_d = cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      sh_q  <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign done_o = run_q && (cnt_q == 3'd7);
  assign bcd_o  = sh_q[19:8];

endmodule

// File: rtl/seg7_display_driver.sv
// 4-digit multiplexed common-anode 7-segment driver for the CPU's Dout/Dval pair.
// Shows Value as unsigned decimal (leading zeros blanked) or as "H" + two hex digits.
// Ports:
//   Clock, Reset : system clock, synchronous active-high reset
//   Value[7:0]   : value to display
//   Valid        : display enable; low blanks the outputs but keeps all state
//   Hex          : 1 = hexadecimal, 0 = unsigned decimal
//   Seg[6:0]     : {g,f,e,d,c,b,a}, active-low, registered
//   An[3:0]      : digit anodes, active-low one-hot, An[0] rightmost, registered
//   Busy         : conversion in progress
module seg7_display_driver
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] Value,
  input  logic       Valid,
  input  logic       Hex,
  output logic [6:0] Seg,
  output logic [3:0] An,
  output logic       Busy
);

  localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(SCAN_DIV - 1);

  state_e            state_q, state_d;
  logic [7:0]        val_q, val_d;
  logic              hex_q, hex_d;
  logic [8:0]        key_q, key_d;
  logic              key_vld_q, key_vld_d;
  logic [3:0][4:0]   digits_q, digits_d;
  logic [3:0][4:0]   new_digits;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [1:0]        idx_q, idx_d;
  logic [3:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;

  logic              conv_start;
  logic              conv_done;
  logic [11:0]       conv_bcd;
  logic              trigger;
  digit_t            cur_digit;
  logic [3:0]        hund, tens, units;

  bin2bcd_seq u_bin2bcd (
    .Clock   (Clock),
    .Reset   (Reset),
    .start_i (conv_start),
    .bin_i   (Value),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd)
  );

  assign trigger = Valid && (!key_vld_q || ({Hex, Value} != key_q));

  // Digit set that the DONE state commits in a single edge
  always_comb begin
    hund  = conv_bcd[11:8];
    tens  = conv_bcd[7:4];
    units = conv_bcd[3:0];
    new_digits = '0;
    if (hex_q) begin
      new_digits[3] = DIG_H;
      new_digits[2] = DIG_BLANK;
      new_digits[1] = hex_digit(val_q[7:4]);
      new_digits[0] = hex_digit(val_q[3:0]);
    end else begin
      new_digits[3] = DIG_BLANK;
      new_digits[2] = (hund == 4'd0) ? DIG_BLANK : hex_digit(hund);
      new_digits[1] = ((hund == 4'd0) && (tens == 4'd0)) ? DIG_BLANK : hex_digit(tens);
      new_digits[0] = hex_digit(units);
    end
  end

  // Conversion controller
  always_comb begin
    state_d    = state_q;
    val_d      = val_q;
    hex_d      = hex_q;
    key_d      = key_q;
    key_vld_d  = key_vld_q;
    digits_d   = digits_q;
    conv_start = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (trigger) begin
          val_d = Value;
          hex_d = Hex;
          if (Hex) begin
            state_d = StDone;
          end else begin
            conv_start = 1'b1;
            state_d    = StConv;
          end
        end
      end
      StConv: begin
        if (conv_done) begin
          state_d = StDone;
        end
      end
      StDone: begin
        digits_d  = new_digits;
        key_d     = {hex_q, val_q};
        key_vld_d = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Digit scan and registered outputs
  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    idx_d = idx_q;
    if (cnt_q == CntLast) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end

    cur_digit = digits_q[idx_q];
    an_d      = 4'b1111;
    seg_d     = SEG_BLANK;
    if (Valid && (cur_digit != DIG_BLANK)) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = seg_encode(cur_digit);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= StIdle;
      val_q     <= '0;
      hex_q     <= 1'b0;
      key_q     <= '0;
      key_vld_q <= 1'b0;
      digits_q  <= {4{DIG_BLANK}};
      cnt_q     <= '0;
      idx_q     <= '0;
      an_q      <= 4'b1111;
      seg_q     <= SEG_BLANK;
    end else begin
      state_q   <= state_d;
      val_q     <= val_d;
      hex_q     <= hex_d;
      key_q     <= key_d;
      key_vld_q <= key_vld_d;
      digits_q  <= digits_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign An   = an_q;
  assign Seg  = seg_q;
  assign Busy = (state_q != StIdle);

endmodule

// File: tb/tb_seg7_display_driver.sv
// Bench for seg7_display_driver with SCAN_DIV=4: directed scenarios plus a randomized run,
// every cycle compared against a cycle-level reference model of the display behaviour.
module tb_seg7_display_driver;

  localparam int SCAN = 4;
  localparam logic [6:0] SEG_TAB [0:16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02,
                                            7'h78, 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21,
                                            7'h06, 7'h0E, 7'h09};

  logic       Clock = 1'b0;
  logic       Reset;
  logic [7:0] Value;
  logic       Valid;
  logic       Hex;
  logic [6:0] Seg;
  logic [3:0] An;
  logic       Busy;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state; digits: -1 blank, 0..15 nibble, 16 letter H
  int         m_left, m_val, m_hex, m_keyv, m_key, m_cnt, m_idx;
  int         m_dig [4];
  logic [3:0] e_an;
  logic [6:0] e_seg;
  logic [7:0] seen [4];

  seg7_display_driver #(.SCAN_DIV(SCAN)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .Value (Value),
    .Valid (Valid),
    .Hex   (Hex),
    .Seg   (Seg),
    .An    (An),
    .Busy  (Busy)
  );

  always #5 Clock = ~Clock;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int h, t, u;
    if (Reset) begin
      m_left = 0; m_keyv = 0; m_key = 0; m_cnt = 0; m_idx = 0;
      for (int i = 0; i < 4; i++) m_dig[i] = -1;
      e_an = 4'hF; e_seg = 7'h7F;
      return;
    end
    if (!Valid || m_dig[m_idx] < 0) begin
      e_an = 4'hF; e_seg = 7'h7F;
    end else begin
      e_an  = 4'(15 - (1 << m_idx));
      e_seg = SEG_TAB[m_dig[m_idx]];
    end
    m_cnt = m_cnt + 1;
    if (m_cnt == SCAN) begin
      m_cnt = 0;
      m_idx = (m_idx + 1) % 4;
    end
    if (m_left == 0) begin
      if (Valid && (!m_keyv || m_key != int'(Hex) * 256 + int'(Value))) begin
        m_val  = int'(Value);
        m_hex  = int'(Hex);
        m_left = Hex ? 1 : 9;
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        if (m_hex != 0) begin
          m_dig[3] = 16; m_dig[2] = -1; m_dig[1] = m_val / 16; m_dig[0] = m_val % 16;
        end else begin
          h = m_val / 100; t = (m_val / 10) % 10; u = m_val % 10;
          m_dig[3] = -1;
          m_dig[2] = (h == 0) ? -1 : h;
          m_dig[1] = (h == 0 && t == 0) ? -1 : t;
          m_dig[0] = u;
        end
        m_keyv = 1;
        m_key  = m_hex * 256 + m_val;
      end
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    model_edge();
    #1;
    check_val("an", {28'd0, An}, {28'd0, e_an});
    check_val("seg", {25'd0, Seg}, {25'd0, e_seg});
    check_val("busy", {31'd0, Busy}, {31'd0, (m_left != 0)});
  endtask

  // Ticks once for the trigger edge, then counts cycles with Busy high (bounded)
  task automatic measure_busy(output int bc);
    tick();
    bc = 0;
    while (Busy === 1'b1 && bc < 40) begin
      bc++;
      tick();
    end
  endtask

  task automatic scan_record(input int n);
    logic [3:0] oh;
    for (int i = 0; i < 4; i++) seen[i] = 8'hFF;
    for (int c = 0; c < n; c++) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        oh = 4'b0001 << i;
        if (An == ~oh) seen[i] = {1'b0, Seg};
      end
    end
  endtask

  // 8'hFF means that digit position was never lit
  task automatic check_scan(input string tag, input logic [7:0] e3, input logic [7:0] e2,
                            input logic [7:0] e1, input logic [7:0] e0);
    scan_record(16);
    check_val($sformatf("%s_d3", tag), {24'd0, seen[3]}, {24'd0, e3});
    check_val($sformatf("%s_d2", tag), {24'd0, seen[2]}, {24'd0, e2});
    check_val($sformatf("%s_d1", tag), {24'd0, seen[1]}, {24'd0, e1});
    check_val($sformatf("%s_d0", tag), {24'd0, seen[0]}, {24'd0, e0});
  endtask

  initial begin
    int bc;
    m_left = 0; m_val = 0; m_hex = 0; m_keyv = 0; m_key = 0; m_cnt = 0; m_idx = 0;
    for (int i = 0; i < 4; i++) m_dig[i] = -1;
    e_an = 4'hF; e_seg = 7'h7F;
    Reset = 1'b1; Valid = 1'b0; Value = 8'd0; Hex = 1'b0;

    // 1: reset, then "0"
    repeat (3) tick();
    check_val("rst_an", {28'd0, An}, 32'hF);
    check_val("rst_seg", {25'd0, Seg}, 32'h7F);
    check_val("rst_busy", {31'd0, Busy}, 32'd0);
    Reset = 1'b0; Valid = 1'b1; Value = 8'd0; Hex = 1'b0;
    measure_busy(bc);
    check_val("t1_busy_len", bc, 9);
    check_scan("t1", 8'hFF, 8'hFF, 8'hFF, 8'h40);

    // 2: 255 decimal
    Value = 8'd255;
    measure_busy(bc);
    check_val("t2_busy_len", bc, 9);
    check_scan("t2", 8'hFF, 8'h24, 8'h12, 8'h12);

    // 3: 7 and 100
    Value = 8'd7;
    measure_busy(bc);
    check_scan("t3a", 8'hFF, 8'hFF, 8'hFF, 8'h78);
    Value = 8'd100;
    measure_busy(bc);
    check_scan("t3b", 8'hFF, 8'h79, 8'h40, 8'h40);

    // 4: hex A5
    Hex = 1'b1; Value = 8'hA5;
    measure_busy(bc);
    check_val("t4_busy_len", bc, 1);
    check_scan("t4", 8'h09, 8'hFF, 8'h08, 8'h12);

    // 5: value change during conversion, then Valid blanking
    Hex = 1'b0; Value = 8'd255;
    tick();                                // edge k
    check_val("t5_start", {31'd0, Busy}, 32'd1);
    tick(); tick();                        // k+1, k+2
    Value = 8'd0;
    repeat (7) tick();                     // through k+9
    check_val("t5_first_done", {31'd0, Busy}, 32'd0);
    tick();                                // k+10 retrigger
    check_val("t5_retrig", {31'd0, Busy}, 32'd1);
    repeat (10) tick();                    // through k+20
    check_val("t5_second_done", {31'd0, Busy}, 32'd0);
    check_scan("t5", 8'hFF, 8'hFF, 8'hFF, 8'h40);
    Valid = 1'b0;
    tick();
    check_val("t5_blank_an", {28'd0, An}, 32'hF);
    repeat (6) tick();
    Valid = 1'b1;
    measure_busy(bc);
    check_val("t5_no_reconv", bc, 0);
    check_scan("t5r", 8'hFF, 8'hFF, 8'hFF, 8'h40);

    // 6: reset in the middle of a conversion
    Value = 8'd255;
    tick();                                // edge k
    repeat (3) tick();                     // k+1..k+3
    Reset = 1'b1;
    tick();                                // k+4
    check_val("t6_an", {28'd0, An}, 32'hF);
    check_val("t6_busy", {31'd0, Busy}, 32'd0);
    Reset = 1'b0;
    scan_record(9);
    for (int i = 0; i < 4; i++) check_val($sformatf("t6_blank_d%0d", i), {24'd0, seen[i]}, 32'hFF);

    // Randomized run
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 99) < 8) Value = 8'($urandom);
      if ($urandom_range(0, 99) < 3) Hex = ~Hex;
      if ($urandom_range(0, 99) < 4) Valid = ~Valid;
      Reset = ($urandom_range(0, 149) == 0);
      tick();
    end
    Reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
